multiplicador_ctrl: RTL and testbench



---
 rtl/mult_pkg.sv | 28 ++
 rtl/multiplicador_ctrl_if.sv | 48 ++++
 rtl/mult_iter_cnt.sv | 40 ++++
 rtl/multiplicador_ctrl.sv | 96 +++++++++
 tb/tb_multiplicador_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: controller state
// encoding and the datapath select encodings used by controller and datapath.
// Optional feature macro used elsewhere in this slice: MULT_CTRL_ABORT_EN.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } mult_state_t;

    // a_sel / b_sel: take the external operand or the shifted register
    localparam logic SEL_EXT   = 1'b0;
    localparam logic SEL_SHIFT = 1'b1;
    // prod_sel: clear the product or take the add-select mux
    localparam logic PROD_CLR  = 1'b0;
    localparam logic PROD_NEXT = 1'b1;
    // add_sel: accumulate A into the product or keep it
    localparam logic ADD_SUM   = 1'b0;
    localparam logic ADD_HOLD  = 1'b1;

    // A set multiplier bit means "add A this iteration"
    function automatic logic add_sel_for(input logic b_lsb);
        return b_lsb ? ADD_SUM : ADD_HOLD;
    endfunction

endpackage

// File: rtl/multiplicador_ctrl_if.sv
// Bundle between the multiplier controller and its surroundings.
// Handshake: start is a request sampled only while the controller is idle
// (busy=0, done=0); there is no queuing, so a start seen at any other time is
// dropped. busy stays high from the load cycle through the last iteration and
// done pulses for one cycle when the product register holds the result.
// Optional abort input exists only with MULT_CTRL_ABORT_EN.
interface multiplicador_ctrl_if #(
    parameter int WIDTH = 32
);
    import mult_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);

    logic          start;
    logic          b_lsb;
    logic          a_sel;
    logic          b_sel;
    logic          prod_sel;
    logic          add_sel;
    logic          busy;
    logic          done;
`ifdef MULT_CTRL_ABORT_EN
    logic          abort;
`endif
    mult_state_t   dbg_state;
    logic [CW-1:0] dbg_cnt;

`ifdef MULT_CTRL_ABORT_EN
    modport master (
        input  start, b_lsb, abort,
        output a_sel, b_sel, prod_sel, add_sel, busy, done, dbg_state, dbg_cnt
    );
    modport slave (
        output start, b_lsb, abort,
        input  a_sel, b_sel, prod_sel, add_sel, busy, done, dbg_state, dbg_cnt
    );
`else
    modport master (
        input  start, b_lsb,
        output a_sel, b_sel, prod_sel, add_sel, busy, done, dbg_state, dbg_cnt
    );
    modport slave (
        output start, b_lsb,
        input  a_sel, b_sel, prod_sel, add_sel, busy, done, dbg_state, dbg_cnt
    );
`endif

endinterface

// File: rtl/mult_iter_cnt.sv
// Iteration counter for the multiplier controller: clear has priority over
// enable, and tc flags the last iteration (cnt == WIDTH-1).
module mult_iter_cnt #(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       en,
    output logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       tc
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear, increment or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/multiplicador_ctrl.sv
// Control FSM for the shift-and-add multiplier: LOAD, WIDTH iterations, DONE.
// All outputs decode from state except add_sel, which follows b_lsb in ITER.
// Optional feature: MULT_CTRL_ABORT_EN adds an abort input on the bus.
module multiplicador_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    multiplicador_ctrl_if.master bus
);
    localparam int CW = $clog2(WIDTH + 1);

    mult_state_t   state_q;
    mult_state_t   state_d;
    logic          cnt_clr;
    logic          cnt_en;
    logic          cnt_tc;
    logic [CW-1:0] cnt;
    logic          abort_req;

`ifdef MULT_CTRL_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    mult_iter_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counter control and select decode
    always_comb begin
        state_d      = state_q;
        cnt_clr      = 1'b1;
        cnt_en       = 1'b0;
        bus.a_sel    = SEL_SHIFT;
        bus.b_sel    = SEL_SHIFT;
        bus.prod_sel = PROD_NEXT;
        bus.add_sel  = ADD_HOLD;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bus.a_sel    = SEL_EXT;
                bus.b_sel    = SEL_EXT;
                bus.prod_sel = PROD_CLR;
                bus.busy     = 1'b1;
                state_d      = abort_req ? IDLE : ITER;
            end
            ITER: begin
                bus.add_sel = add_sel_for(bus.b_lsb);
                bus.busy    = 1'b1;
                // Clearing on the last iteration leaves cnt at 0 in DONE
                cnt_clr     = cnt_tc || abort_req;
                cnt_en      = 1'b1;
                if (abort_req) begin
                    state_d = IDLE;
                end else if (cnt_tc) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.dbg_state = state_q;
    assign bus.dbg_cnt   = cnt;

endmodule

// File: tb/tb_multiplicador_ctrl.sv
// Directed bench for multiplicador_ctrl at WIDTH=32 and WIDTH=4.
// Abort scenario is compiled in with MULT_CTRL_ABORT_EN.
module tb_multiplicador_ctrl;
    import mult_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multiplicador_ctrl_if #(.WIDTH(32)) if32 ();
    multiplicador_ctrl_if #(.WIDTH(4))  if4 ();

    multiplicador_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));
    multiplicador_ctrl #(.WIDTH(4))  dut4  (.clk(clk), .reset(reset), .bus(if4));

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Selects as {a_sel, b_sel, prod_sel, add_sel}
    function automatic logic [31:0] sels32();
        return {28'd0, if32.a_sel, if32.b_sel, if32.prod_sel, if32.add_sel};
    endfunction

    function automatic logic [31:0] sels4();
        return {28'd0, if4.a_sel, if4.b_sel, if4.prod_sel, if4.add_sel};
    endfunction

    // One-cycle start pulse on the 32-bit unit; returns after edge 0
    task automatic pulse_start32();
        if32.start = 1'b1;
        tick();
        if32.start = 1'b0;
    endtask

    // From cycle 0 (after the start edge), count busy cycles and done pulses
    task automatic measure32(output int busy_n, output int done_at, output int done_n);
        busy_n  = if32.busy ? 1 : 0;
        done_n  = if32.done ? 1 : 0;
        done_at = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (if32.busy) busy_n++;
            if (if32.done) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
        end
    endtask

    logic [31:0] bv32;
    logic [3:0]  bv4;
    logic        exp_bit;
    int          busy_n;
    int          done_n;
    int          done_at;
    int          done_at2;

    initial begin
        reset       = 1'b1;
        if32.start  = 1'b0;
        if32.b_lsb  = 1'b0;
        if4.start   = 1'b0;
        if4.b_lsb   = 1'b0;
`ifdef MULT_CTRL_ABORT_EN
        if32.abort  = 1'b0;
        if4.abort   = 1'b0;
`endif
        #23;
        // ---- reset state ----
        check("rst_state",   if32.dbg_state, IDLE);
        check("rst_busy",    if32.busy, 1'b0);
        check("rst_done",    if32.done, 1'b0);
        check("rst_sels",    sels32(), 32'hF);
        check("rst_cnt",     if32.dbg_cnt, 0);
        check("rst_busy_w4", if4.busy, 1'b0);
        reset = 1'b0;
        tick();
        tick();

        // ---- single multiply, b = 5 ----
        bv32 = 32'd5;
        pulse_start32();
        check("load_state", if32.dbg_state, LOAD);
        check("load_busy",  if32.busy, 1'b1);
        check("load_sels",  sels32(), 32'h1);
        check("load_done",  if32.done, 1'b0);
        busy_n = 1;
        for (int i = 0; i < 32; i++) begin
            tick();
            if32.b_lsb = bv32[i];
            #1;
            exp_bit = ~bv32[i];
            check("iter_add_sel", if32.add_sel, exp_bit);
            check("iter_state",   if32.dbg_state, ITER);
            check("iter_cnt",     if32.dbg_cnt, i);
            check("iter_done",    if32.done, 1'b0);
            if (if32.busy) busy_n++;
        end
        check("run1_busy_cycles", busy_n, 33);
        tick();
        check("done_pulse", if32.done, 1'b1);
        check("done_busy",  if32.busy, 1'b0);
        check("done_sels",  sels32(), 32'hF);
        tick();
        check("post_done_state", if32.dbg_state, IDLE);
        check("post_done_done",  if32.done, 1'b0);

        // ---- start held high: period WIDTH+3 ----
        if32.start = 1'b1;
        busy_n   = 0;
        done_n   = 0;
        done_at  = -1;
        done_at2 = -1;
        for (int c = 0; c < 70; c++) begin
            tick();
            if (if32.busy) busy_n++;
            if (if32.done) begin
                done_n++;
                if (done_at < 0) done_at = c;
                else done_at2 = c;
            end
        end
        if32.start = 1'b0;
        check("held_busy_cycles", busy_n, 66);
        check("held_done_count",  done_n, 2);
        check("held_done_first",  done_at, 33);
        check("held_done_second", done_at2, 68);
        check("held_end_state",   if32.dbg_state, IDLE);
        tick();
        tick();

        // ---- async reset mid-ITER at cnt = 10 ----
        pulse_start32();
        if32.b_lsb = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        check("pre_rst_cnt",     if32.dbg_cnt, 10);
        check("pre_rst_add_sel", if32.add_sel, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_state", if32.dbg_state, IDLE);
        check("async_rst_busy",  if32.busy, 1'b0);
        check("async_rst_sels",  sels32(), 32'hF);
        check("async_rst_cnt",   if32.dbg_cnt, 0);
        check("async_rst_done",  if32.done, 1'b0);
        #3;
        reset = 1'b0;
        if32.b_lsb = 1'b0;
        tick();
        pulse_start32();
        measure32(busy_n, done_at, done_n);
        check("after_rst_busy_cycles", busy_n, 33);
        check("after_rst_done_at",     done_at, 33);
        check("after_rst_done_count",  done_n, 1);

`ifdef MULT_CTRL_ABORT_EN
        // ---- abort at ITER cnt = 3 ----
        tick();
        pulse_start32();
        for (int i = 0; i < 4; i++) tick();
        check("pre_abort_cnt", if32.dbg_cnt, 3);
        if32.abort = 1'b1;
        tick();
        if32.abort = 1'b0;
        check("abort_state", if32.dbg_state, IDLE);
        check("abort_busy",  if32.busy, 1'b0);
        check("abort_done",  if32.done, 1'b0);
        done_n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (if32.done) done_n++;
        end
        check("abort_no_done", done_n, 0);
        pulse_start32();
        measure32(busy_n, done_at, done_n);
        check("after_abort_busy_cycles", busy_n, 33);
        check("after_abort_done_at",     done_at, 33);
`endif

        // ---- WIDTH = 4, b = 4'b1011 ----
        bv4 = 4'b1011;
        if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        check("w4_load_sels", sels4(), 32'h1);
        busy_n = if4.busy ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if4.b_lsb = bv4[i];
            #1;
            exp_bit = ~bv4[i];
            check("w4_add_sel", if4.add_sel, exp_bit);
            if (if4.busy) busy_n++;
        end
        check("w4_busy_cycles", busy_n, 5);
        tick();
        check("w4_done_at_5", if4.done, 1'b1);
        check("w4_done_busy", if4.busy, 1'b0);
        tick();
        check("w4_idle_at_6", if4.dbg_state, IDLE);
        check("w4_done_low",  if4.done, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
